ctl_game: RTL and testbench

CTL_GAME -- requirements
Module: ctl_game

---
 rtl/ctl_game.sv | 150 +++++++++++++++
 tb/tb_ctl_game.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctl_game.sv
// Game controller for a duck-hunt style round.
// One duck is launched at a time. Each duck is either hit (FALL) or escapes
// (ESCAPE). After DUCKS_PER_ROUND ducks, ROUND_END decides between advancing
// to the next round and GAME_OVER. All timing is counted in VGA frames.
// Every output comes straight from a flop, and state is exposed for observation.
module ctl_game #(
  parameter int FLIGHT_FRAMES   = 600,
  parameter int FALL_FRAMES     = 60,
  parameter int ESCAPE_FRAMES   = 60,
  parameter int END_FRAMES      = 120,
  parameter int DUCKS_PER_ROUND = 10,
  parameter int PASS_HITS       = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_frame,
  input  logic       start,
  input  logic       pause,
  input  logic       hit,
  input  logic       no_ammo,
  output logic       duck_launch,
  output logic       duck_escaped,
  output logic       round_active,
  output logic       game_over,
  output logic [3:0] duck_count,
  output logic [3:0] ducks_hit,
  output logic [3:0] round_num,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_FLIGHT    = 3'd2,
    S_FALL      = 3'd3,
    S_ESCAPE    = 3'd4,
    S_ROUND_END = 3'd5,
    S_GAME_OVER = 3'd6
  } state_t;

  localparam logic [9:0] FLIGHT_LAST = 10'(FLIGHT_FRAMES - 1);
  localparam logic [9:0] FALL_LAST   = 10'(FALL_FRAMES - 1);
  localparam logic [9:0] ESCAPE_LAST = 10'(ESCAPE_FRAMES - 1);
  localparam logic [9:0] END_LAST    = 10'(END_FRAMES - 1);
  localparam logic [3:0] DUCKS_MAX   = 4'(DUCKS_PER_ROUND);
  localparam logic [3:0] HITS_NEEDED = 4'(PASS_HITS);

  state_t     state_q, state_nx;
  logic [9:0] frame_cnt, frame_cnt_nx;
  logic [3:0] duck_count_nx, ducks_hit_nx, round_num_nx;
  logic       launch_nx, escaped_nx, active_nx, over_nx;
  logic       frame_tick;

  assign state = state_q;

  // Next-state, counter updates and pulse generation. start beats pause.
  // pause freezes everything else, including frames, hit and no_ammo.
  always_comb begin
    state_nx      = state_q;
    duck_count_nx = duck_count;
    ducks_hit_nx  = ducks_hit;
    round_num_nx  = round_num;
    launch_nx     = 1'b0;
    escaped_nx    = 1'b0;
    frame_tick    = new_frame && !pause;

    if (start) begin
      state_nx      = S_LAUNCH;
      duck_count_nx = 4'd0;
      ducks_hit_nx  = 4'd0;
      round_num_nx  = 4'd1;
    end else if (!pause) begin
      case (state_q)
        S_IDLE: ;
        S_LAUNCH: begin
          state_nx  = S_FLIGHT;
          launch_nx = 1'b1;
          if (duck_count < DUCKS_MAX) duck_count_nx = duck_count + 4'd1;
        end
        S_FLIGHT: begin
          if (hit) begin
            state_nx = S_FALL;
            if (ducks_hit != 4'd15) ducks_hit_nx = ducks_hit + 4'd1;
          end else if ((frame_tick && frame_cnt == FLIGHT_LAST) || no_ammo) begin
            state_nx   = S_ESCAPE;
            escaped_nx = 1'b1;
          end
        end
        S_FALL: begin
          if (frame_tick && frame_cnt == FALL_LAST)
            state_nx = (duck_count == DUCKS_MAX) ? S_ROUND_END : S_LAUNCH;
        end
        S_ESCAPE: begin
          if (frame_tick && frame_cnt == ESCAPE_LAST)
            state_nx = (duck_count == DUCKS_MAX) ? S_ROUND_END : S_LAUNCH;
        end
        S_ROUND_END: begin
          if (frame_tick && frame_cnt == END_LAST) begin
            if (ducks_hit >= HITS_NEEDED) begin
              state_nx      = S_LAUNCH;
              duck_count_nx = 4'd0;
              ducks_hit_nx  = 4'd0;
              if (round_num != 4'd15) round_num_nx = round_num + 4'd1;
            end else begin
              state_nx = S_GAME_OVER;
            end
          end
        end
        S_GAME_OVER: ;
        default: state_nx = S_IDLE;
      endcase
    end

    // The frame counter restarts on every state entry, including a start
    // that re-enters LAUNCH from LAUNCH.
    if (start || state_nx != state_q) frame_cnt_nx = 10'd0;
    else if (frame_tick)              frame_cnt_nx = frame_cnt + 10'd1;
    else                              frame_cnt_nx = frame_cnt;

    active_nx = (state_nx == S_LAUNCH) || (state_nx == S_FLIGHT) ||
                (state_nx == S_FALL)   || (state_nx == S_ESCAPE);
    over_nx   = (state_nx == S_GAME_OVER);
  end

  // State register and registered outputs; reset forces everything to zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      frame_cnt    <= 10'd0;
      duck_count   <= 4'd0;
      ducks_hit    <= 4'd0;
      round_num    <= 4'd0;
      duck_launch  <= 1'b0;
      duck_escaped <= 1'b0;
      round_active <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      state_q      <= state_nx;
      frame_cnt    <= frame_cnt_nx;
      duck_count   <= duck_count_nx;
      ducks_hit    <= ducks_hit_nx;
      round_num    <= round_num_nx;
      duck_launch  <= launch_nx;
      duck_escaped <= escaped_nx;
      round_active <= active_nx;
      game_over    <= over_nx;
    end
  end

endmodule

// File: tb/tb_ctl_game.sv
// Bench for ctl_game. It runs short frame timings, a set of directed
// scenarios and a randomized run checked against a countdown-based game model.
module tb_ctl_game;

  localparam int FLIGHT = 4;
  localparam int FALL   = 2;
  localparam int ESC    = 3;
  localparam int ENDF   = 3;
  localparam int DPR    = 2;
  localparam int PASS   = 2;

  logic       clk = 1'b0;
  logic       rst, new_frame, start, pause, hit, no_ammo;
  logic       duck_launch, duck_escaped, round_active, game_over;
  logic [3:0] duck_count, ducks_hit, round_num;
  logic [2:0] state;

  int vectors = 0;
  int errors  = 0;

  ctl_game #(
    .FLIGHT_FRAMES(FLIGHT), .FALL_FRAMES(FALL), .ESCAPE_FRAMES(ESC),
    .END_FRAMES(ENDF), .DUCKS_PER_ROUND(DPR), .PASS_HITS(PASS)
  ) dut (
    .clk(clk), .rst(rst), .new_frame(new_frame), .start(start), .pause(pause),
    .hit(hit), .no_ammo(no_ammo), .duck_launch(duck_launch),
    .duck_escaped(duck_escaped), .round_active(round_active),
    .game_over(game_over), .duck_count(duck_count), .ducks_hit(ducks_hit),
    .round_num(round_num), .state(state)
  );

  // Clock
  always #5 clk = ~clk;

  // Observed outputs packed as {state, duck_count, ducks_hit, round_num,
  // duck_launch, duck_escaped, round_active, game_over}.
  function automatic logic [18:0] snap();
    return {state, duck_count, ducks_hit, round_num,
            duck_launch, duck_escaped, round_active, game_over};
  endfunction

  // Expected output vector; round_active and game_over follow from the state.
  function automatic logic [18:0] exp_v(int st, int dc, int dh, int rn, int dl, int de);
    logic ra, go;
    ra = (st >= 1 && st <= 4);
    go = (st == 6);
    return {3'(st), 4'(dc), 4'(dh), 4'(rn), 1'(dl), 1'(de), ra, go};
  endfunction

  // Driver: apply one cycle of inputs, then sample on the falling edge.
  task automatic drive(input logic r, input logic s, input logic p,
                       input logic nf, input logic h, input logic na);
    rst = r; start = s; pause = p; new_frame = nf; hit = h; no_ammo = na;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: each phase counts its remaining frames down.
  int m_ph, m_left, m_dc, m_dh, m_rn, m_dl, m_de;

  task automatic model_step(input logic r, input logic s, input logic p,
                            input logic nf, input logic h, input logic na);
    m_dl = 0;
    m_de = 0;
    if (!r) begin
      m_ph = 0; m_dc = 0; m_dh = 0; m_rn = 0; m_left = 0;
    end else if (s) begin
      m_ph = 1; m_dc = 0; m_dh = 0; m_rn = 1;
    end else if (!p) begin
      if (m_ph == 1) begin
        m_ph = 2; m_dc = m_dc + 1; m_dl = 1; m_left = FLIGHT;
      end else if (m_ph == 2) begin
        if (h) begin
          m_ph = 3; m_left = FALL;
          m_dh = (m_dh == 15) ? 15 : m_dh + 1;
        end else if ((nf && m_left == 1) || na) begin
          m_ph = 4; m_de = 1; m_left = ESC;
        end else if (nf) begin
          m_left = m_left - 1;
        end
      end else if (m_ph == 3 || m_ph == 4) begin
        if (nf && m_left == 1) begin
          if (m_dc == DPR) begin m_ph = 5; m_left = ENDF; end
          else m_ph = 1;
        end else if (nf) begin
          m_left = m_left - 1;
        end
      end else if (m_ph == 5) begin
        if (nf && m_left == 1) begin
          if (m_dh >= PASS) begin
            m_ph = 1; m_dc = 0; m_dh = 0;
            m_rn = (m_rn == 15) ? 15 : m_rn + 1;
          end else begin
            m_ph = 6;
          end
        end else if (nf) begin
          m_left = m_left - 1;
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [18:0] e;
    e = exp_v(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      vectors++;
      if (snap() !== e) begin
        errors++; $display("FAIL reset_%0d got %h exp %h", i, snap(), e);
      end
    end
    drive(1, 0, 0, 1, 1, 1);
    vectors++;
    if (snap() !== e) begin
      errors++; $display("FAIL idle_ignores_hit got %h exp %h", snap(), e);
    end
  endtask

  task automatic test_launch_escape();
    logic [18:0] e;
    drive(1, 1, 0, 0, 0, 0);
    e = exp_v(1, 0, 0, 1, 0, 0); vectors++;
    if (snap() !== e) begin errors++; $display("FAIL start_launch got %h exp %h", snap(), e); end
    drive(1, 0, 0, 0, 0, 0);
    e = exp_v(2, 1, 0, 1, 1, 0); vectors++;
    if (snap() !== e) begin errors++; $display("FAIL launch_pulse got %h exp %h", snap(), e); end
    e = exp_v(2, 1, 0, 1, 0, 0);
    for (int i = 0; i < FLIGHT - 1; i++) begin
      drive(1, 0, 0, 1, 0, 0); vectors++;
      if (snap() !== e) begin errors++; $display("FAIL flight_wait_%0d got %h exp %h", i, snap(), e); end
    end
    drive(1, 0, 0, 1, 0, 0);
    e = exp_v(4, 1, 0, 1, 0, 1); vectors++;
    if (snap() !== e) begin errors++; $display("FAIL timeout_escape got %h exp %h", snap(), e); end
    drive(1, 0, 0, 0, 0, 0);
    e = exp_v(4, 1, 0, 1, 0, 0); vectors++;
    if (snap() !== e) begin errors++; $display("FAIL escape_pulse_end got %h exp %h", snap(), e); end
    for (int i = 0; i < ESC - 1; i++) begin
      drive(1, 0, 0, 1, 0, 0); vectors++;
      if (snap() !== e) begin errors++; $display("FAIL escape_wait_%0d got %h exp %h", i, snap(), e); end
    end
    drive(1, 0, 0, 1, 0, 0);
    e = exp_v(1, 1, 0, 1, 0, 0); vectors++;
    if (snap() !== e) begin errors++; $display("FAIL escape_to_launch got %h exp %h", snap(), e); end
    drive(1, 0, 0, 0, 0, 0);
    e = exp_v(2, 2, 0, 1, 1, 0); vectors++;
    if (snap() !== e) begin errors++; $display("FAIL second_launch got %h exp %h", snap(), e); end
    drive(1, 0, 0, 0, 0, 1);
    e = exp_v(4, 2, 0, 1, 0, 1); vectors++;
    if (snap() !== e) begin errors++; $display("FAIL no_ammo_escape got %h exp %h", snap(), e); end
    e = exp_v(4, 2, 0, 1, 0, 0);
    for (int i = 0; i < ESC - 1; i++) begin
      drive(1, 0, 0, 1, 0, 0); vectors++;
      if (snap() !== e) begin errors++; $display("FAIL escape2_wait_%0d got %h exp %h", i, snap(), e); end
    end
    drive(1, 0, 0, 1, 0, 0);
    e = exp_v(5, 2, 0, 1, 0, 0); vectors++;
    if (snap() !== e) begin errors++; $display("FAIL round_end_entry got %h exp %h", snap(), e); end
    for (int i = 0; i < ENDF - 1; i++) begin
      drive(1, 0, 0, 1, 0, 0); vectors++;
      if (snap() !== e) begin errors++; $display("FAIL round_end_wait_%0d got %h exp %h", i, snap(), e); end
    end
    drive(1, 0, 0, 1, 0, 0);
    e = exp_v(6, 2, 0, 1, 0, 0); vectors++;
    if (snap() !== e) begin errors++; $display("FAIL game_over got %h exp %h", snap(), e); end
    drive(1, 0, 0, 1, 1, 1); vectors++;
    if (snap() !== e) begin errors++; $display("FAIL game_over_hold got %h exp %h", snap(), e); end
    drive(1, 1, 0, 0, 0, 0);
    e = exp_v(1, 0, 0, 1, 0, 0); vectors++;
    if (snap() !== e) begin errors++; $display("FAIL restart got %h exp %h", snap(), e); end
  endtask

  task automatic test_hit_wins();
    logic [18:0] e;
    drive(1, 0, 0, 0, 0, 0);
    e = exp_v(2, 1, 0, 1, 1, 0); vectors++;
    if (snap() !== e) begin errors++; $display("FAIL hw_launch got %h exp %h", snap(), e); end
    for (int i = 0; i < FLIGHT - 1; i++) drive(1, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 1, 1, 0);
    e = exp_v(3, 1, 1, 1, 0, 0); vectors++;
    if (snap() !== e) begin errors++; $display("FAIL hit_beats_timeout got %h exp %h", snap(), e); end
    drive(1, 0, 0, 1, 0, 0); vectors++;
    if (snap() !== e) begin errors++; $display("FAIL fall_wait got %h exp %h", snap(), e); end
    drive(1, 0, 0, 1, 0, 0);
    e = exp_v(1, 1, 1, 1, 0, 0); vectors++;
    if (snap() !== e) begin errors++; $display("FAIL fall_to_launch got %h exp %h", snap(), e); end
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 1);
    e = exp_v(3, 2, 2, 1, 0, 0); vectors++;
    if (snap() !== e) begin errors++; $display("FAIL hit_beats_no_ammo got %h exp %h", snap(), e); end
    for (int i = 0; i < FALL; i++) drive(1, 0, 0, 1, 0, 0);
    e = exp_v(5, 2, 2, 1, 0, 0); vectors++;
    if (snap() !== e) begin errors++; $display("FAIL fall_to_round_end got %h exp %h", snap(), e); end
    for (int i = 0; i < ENDF; i++) drive(1, 0, 0, 1, 0, 0);
    e = exp_v(1, 0, 0, 2, 0, 0); vectors++;
    if (snap() !== e) begin errors++; $display("FAIL next_round got %h exp %h", snap(), e); end
    drive(1, 0, 0, 0, 0, 0);
    e = exp_v(2, 1, 0, 2, 1, 0); vectors++;
    if (snap() !== e) begin errors++; $display("FAIL round2_launch got %h exp %h", snap(), e); end
  endtask

  task automatic test_pause();
    logic [18:0] e;
    drive(1, 0, 0, 1, 0, 0);
    e = exp_v(2, 1, 0, 2, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 1, 1, (i == 4), (i == 7)); vectors++;
      if (snap() !== e) begin errors++; $display("FAIL pause_hold_%0d got %h exp %h", i, snap(), e); end
    end
    for (int i = 0; i < FLIGHT - 2; i++) begin
      drive(1, 0, 0, 1, 0, 0); vectors++;
      if (snap() !== e) begin errors++; $display("FAIL resume_wait_%0d got %h exp %h", i, snap(), e); end
    end
    drive(1, 0, 0, 1, 0, 0);
    e = exp_v(4, 1, 0, 2, 0, 1); vectors++;
    if (snap() !== e) begin errors++; $display("FAIL resume_escape got %h exp %h", snap(), e); end
    for (int i = 0; i < ESC; i++) drive(1, 0, 0, 1, 0, 0);
    e = exp_v(1, 1, 0, 2, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 1, 0, 0); vectors++;
      if (snap() !== e) begin errors++; $display("FAIL launch_pause_%0d got %h exp %h", i, snap(), e); end
    end
    drive(1, 0, 0, 0, 0, 0);
    e = exp_v(2, 2, 0, 2, 1, 0); vectors++;
    if (snap() !== e) begin errors++; $display("FAIL launch_after_pause got %h exp %h", snap(), e); end
    drive(1, 1, 1, 0, 0, 0);
    e = exp_v(1, 0, 0, 1, 0, 0); vectors++;
    if (snap() !== e) begin errors++; $display("FAIL start_over_pause got %h exp %h", snap(), e); end
  endtask

  task automatic test_reset_mid_fall();
    logic [18:0] e;
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 0);
    e = exp_v(3, 1, 1, 1, 0, 0); vectors++;
    if (snap() !== e) begin errors++; $display("FAIL rmf_fall got %h exp %h", snap(), e); end
    drive(0, 1, 0, 1, 1, 0);
    e = exp_v(0, 0, 0, 0, 0, 0); vectors++;
    if (snap() !== e) begin errors++; $display("FAIL reset_mid_fall got %h exp %h", snap(), e); end
    drive(1, 0, 0, 1, 1, 0); vectors++;
    if (snap() !== e) begin errors++; $display("FAIL hit_after_reset got %h exp %h", snap(), e); end
    drive(1, 1, 0, 0, 0, 0);
    e = exp_v(1, 0, 0, 1, 0, 0); vectors++;
    if (snap() !== e) begin errors++; $display("FAIL start_after_reset got %h exp %h", snap(), e); end
  endtask

  task automatic test_random();
    logic [18:0] e;
    logic r, s, p, nf, h, na;
    drive(0, 0, 0, 0, 0, 0);
    model_step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 299) != 0);
      s  = ($urandom_range(0, 79) == 0);
      p  = ($urandom_range(0, 7) == 0);
      nf = ($urandom_range(0, 1) == 0);
      h  = ($urandom_range(0, 9) == 0);
      na = ($urandom_range(0, 24) == 0);
      drive(r, s, p, nf, h, na);
      model_step(r, s, p, nf, h, na);
      e = exp_v(m_ph, m_dc, m_dh, m_rn, m_dl, m_de);
      vectors++;
      if (snap() !== e) begin
        errors++; $display("FAIL random_%0d got %h exp %h", i, snap(), e);
      end
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; pause = 1'b0;
    new_frame = 1'b0; hit = 1'b0; no_ammo = 1'b0;
    test_reset();
    test_launch_escape();
    test_hit_wins();
    test_pause();
    test_reset_mid_fall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
